// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared constants and types for the SPI flash read sequencer
//
// Contents:
//   REG_CONFIG / REG_DATA / REG_INJECT  SPI master register addresses
//   CFG_SS_BIT / CFG_DISCARD_BIT        bit positions inside the config register
//   seq_state_t                         sequencer states, one per register operation
//   op_state_t                          single-op Wishbone handshake states
//   cfg_byte()                          builds a config register value

package spi_seq_pkg;

  localparam logic [7:0] REG_CONFIG = 8'h01;
  localparam logic [7:0] REG_DATA   = 8'h02;
  localparam logic [7:0] REG_INJECT = 8'h03;

  localparam int CFG_SS_BIT      = 0;
  localparam int CFG_DISCARD_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_ON,
    ST_CMD,
    ST_ADDR,
    ST_RX_ON,
    ST_INJECT,
    ST_READ,
    ST_CS_OFF
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_ISSUE,
    OP_WAIT_ACK
  } op_state_t;

  // ss is the raw (active-low) chip-select level written to the SPI master.
  function automatic logic [7:0] cfg_byte(input logic ss, input logic discard);
    logic [7:0] b;
    b                  = 8'h00;
    b[CFG_SS_BIT]      = ss;
    b[CFG_DISCARD_BIT] = discard;
    return b;
  endfunction

endpackage

// File: rtl/wb_single_op_master.sv
// rtl/wb_single_op_master.sv - runs one pipelined Wishbone transaction at a time
//
// Ports:
//   clk, sresetn               clock, synchronous active-low reset
//   start_i, we_i, addr_i,     operation request; accepted when idle or in the
//   wdata_i                    cycle the previous operation is acked
//   done_o, rdata_o            ack seen this cycle (combinational), read data
//   wb_stb_o, wb_we_o,         registered Wishbone master outputs
//   wb_addr_o, wb_dat_o
//   wb_ack_i, wb_stall_i,      Wishbone slave responses
//   wb_dat_i

module wb_single_op_master
  import spi_seq_pkg::*;
(
  input  logic       clk,
  input  logic       sresetn,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [7:0] wb_addr_o,
  output logic [7:0] wb_dat_o,
  input  logic       wb_ack_i,
  input  logic       wb_stall_i,
  input  logic [7:0] wb_dat_i
);

  op_state_t  state_q;
  logic       stb_q;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] dat_q;
  logic       free;

  // done is combinational so the caller can chain the next op into the ack
  // cycle, giving the next stb one cycle after the ack.
  assign done_o  = (state_q == OP_WAIT_ACK) && wb_ack_i;
  assign rdata_o = wb_dat_i;
  assign free    = (state_q == OP_IDLE) || done_o;

  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = dat_q;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= OP_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      dat_q   <= 8'h00;
    end else if (free && start_i) begin
      state_q <= OP_ISSUE;
      stb_q   <= 1'b1;
      we_q    <= we_i;
      addr_q  <= addr_i;
      dat_q   <= wdata_i;
    end else if ((state_q == OP_ISSUE) && !wb_stall_i) begin
      // ack is not looked at here: it can only follow an accepted stb
      state_q <= OP_WAIT_ACK;
      stb_q   <= 1'b0;
    end else if (done_o) begin
      state_q <= OP_IDLE;
    end
  end

endmodule

// File: rtl/spi_flash_read_sequencer.sv
// rtl/spi_flash_read_sequencer.sv - drives the SPI master registers to perform flash READs
//
// Ports:
//   clk, sresetn                         clock, synchronous active-low reset
//   req_valid/req_ready/req_addr/req_len read request (len 0 is dropped)
//   busy                                 sequence in progress
//   m_axis_tvalid/tready/tdata/tlast     read data out, tlast on final byte
//   m_wb_*                               pipelined Wishbone master to the SPI master

module spi_flash_read_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 3,
  parameter logic [7:0]  CMD_READ   = 8'h03
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [7:0]              req_len,
  output logic                    busy,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [7:0]              m_wb_addr,
  output logic [7:0]              m_wb_dat_m2s,
  input  logic [7:0]              m_wb_dat_s2m,
  output logic                    m_wb_we,
  output logic                    m_wb_sel,
  output logic                    m_wb_stb,
  output logic                    m_wb_cyc,
  input  logic                    m_wb_ack,
  input  logic                    m_wb_stall
);

  localparam int unsigned AW = 8 * ADDR_BYTES;

  seq_state_t    state_q;
  logic          issued_q;   // op belonging to state_q is in flight
  logic [AW-1:0] addr_q;     // shifted left as address bytes are launched
  logic [2:0]    ab_q;       // address bytes launched
  logic [7:0]    len_q;
  logic [7:0]    rd_q;       // reads launched
  logic          cyc_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic [7:0]    tdata_q;

  logic          op_done;
  logic [7:0]    op_rdata;
  logic          op_we;
  logic [7:0]    op_addr;
  logic [7:0]    op_wdata;

  logic          accept;
  seq_state_t    after_done;
  seq_state_t    tgt;
  logic          want;
  logic          out_free;
  logic          launch;

  always_comb begin
    accept = (state_q == ST_IDLE) && req_valid && (req_len != 8'd0);

    after_done = ST_IDLE;
    unique case (state_q)
      ST_CS_ON:  after_done = ST_CMD;
      ST_CMD:    after_done = ST_ADDR;
      ST_ADDR:   after_done = (ab_q == 3'(ADDR_BYTES)) ? ST_RX_ON : ST_ADDR;
      ST_RX_ON:  after_done = ST_INJECT;
      ST_INJECT: after_done = ST_READ;
      ST_READ:   after_done = (rd_q == len_q) ? ST_CS_OFF : ST_READ;
      ST_CS_OFF: after_done = ST_IDLE;
      default:   after_done = ST_IDLE;
    endcase

    // Which state's op may be started this cycle: a fresh request, an op that
    // was held back, or the successor of an op acked this cycle.
    if (state_q == ST_IDLE) begin
      tgt  = ST_CS_ON;
      want = accept;
    end else if (!issued_q) begin
      tgt  = state_q;
      want = 1'b1;
    end else begin
      tgt  = after_done;
      want = op_done && (after_done != ST_IDLE);
    end

    // A read ack this cycle fills the output register next cycle, so it
    // counts as full; otherwise it must be empty or draining now.
    out_free = (!tvalid_q || m_axis_tready) && !(op_done && (state_q == ST_READ));
    launch   = want && ((tgt != ST_READ) || out_free);

    op_we    = 1'b1;
    op_addr  = REG_CONFIG;
    op_wdata = 8'h00;
    case (tgt)
      ST_CS_ON:  op_wdata = cfg_byte(1'b0, 1'b1);
      ST_CMD: begin
        op_addr  = REG_DATA;
        op_wdata = CMD_READ;
      end
      ST_ADDR: begin
        op_addr  = REG_DATA;
        op_wdata = addr_q[AW-1 -: 8];
      end
      ST_RX_ON:  op_wdata = cfg_byte(1'b0, 1'b0);
      ST_INJECT: begin
        op_addr  = REG_INJECT;
        op_wdata = len_q;
      end
      ST_READ: begin
        op_we   = 1'b0;
        op_addr = REG_DATA;
      end
      ST_CS_OFF: op_wdata = cfg_byte(1'b1, 1'b0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q  <= ST_IDLE;
      issued_q <= 1'b0;
      addr_q   <= '0;
      ab_q     <= 3'd0;
      len_q    <= 8'd0;
      rd_q     <= 8'd0;
      cyc_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= 8'h00;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        ab_q   <= 3'd0;
        rd_q   <= 8'd0;
      end

      if (launch) begin
        issued_q <= 1'b1;
        if (tgt == ST_CS_ON) cyc_q <= 1'b1;
        if (tgt == ST_ADDR) begin
          addr_q <= addr_q << 8;
          ab_q   <= ab_q + 3'd1;
        end
        if (tgt == ST_READ) rd_q <= rd_q + 8'd1;
      end else if (op_done) begin
        issued_q <= 1'b0;
      end

      if (state_q == ST_IDLE) begin
        if (accept) state_q <= ST_CS_ON;
      end else if (issued_q && op_done) begin
        state_q <= after_done;
      end

      if (op_done && (state_q == ST_CS_OFF)) cyc_q <= 1'b0;

      if (op_done && (state_q == ST_READ)) begin
        tdata_q  <= op_rdata;
        tvalid_q <= 1'b1;
        tlast_q  <= (rd_q == len_q);
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  wb_single_op_master u_op (
    .clk       (clk),
    .sresetn   (sresetn),
    .start_i   (launch),
    .we_i      (op_we),
    .addr_i    (op_addr),
    .wdata_i   (op_wdata),
    .done_o    (op_done),
    .rdata_o   (op_rdata),
    .wb_stb_o  (m_wb_stb),
    .wb_we_o   (m_wb_we),
    .wb_addr_o (m_wb_addr),
    .wb_dat_o  (m_wb_dat_m2s),
    .wb_ack_i  (m_wb_ack),
    .wb_stall_i(m_wb_stall),
    .wb_dat_i  (m_wb_dat_s2m)
  );

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign m_wb_cyc      = cyc_q;
  assign m_wb_sel      = 1'b1;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// tb/tb_spi_flash_read_sequencer.sv - randomized self-checking bench for the read sequencer

module tb_spi_flash_read_sequencer;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_len = 8'h0;
  logic        busy;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic [7:0]  m_wb_addr;
  logic [7:0]  m_wb_dat_m2s;
  logic [7:0]  m_wb_dat_s2m = 8'h0;
  logic        m_wb_we;
  logic        m_wb_sel;
  logic        m_wb_stb;
  logic        m_wb_cyc;
  logic        m_wb_ack = 1'b0;
  logic        m_wb_stall = 1'b0;

  spi_flash_read_sequencer dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .busy         (busy),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_wb_addr    (m_wb_addr),
    .m_wb_dat_m2s (m_wb_dat_m2s),
    .m_wb_dat_s2m (m_wb_dat_s2m),
    .m_wb_we      (m_wb_we),
    .m_wb_sel     (m_wb_sel),
    .m_wb_stb     (m_wb_stb),
    .m_wb_cyc     (m_wb_cyc),
    .m_wb_ack     (m_wb_ack),
    .m_wb_stall   (m_wb_stall)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] TX_RX_ON  = {1'b1, 8'h01, 8'h00};
  localparam logic [16:0] TX_CS_OFF = {1'b1, 8'h01, 8'h01};

  int n_checks = 0;
  int n_errors = 0;

  // reference model and slave state
  logic [16:0] exp_txn[$];
  logic [7:0]  exp_bytes[$];
  int          cyc_n = 0;
  bit          model_en = 0;
  bit          pend = 0;
  logic [16:0] pend_txn;
  logic [7:0]  pend_rd;
  int          ack_wait = 0;
  bit          holding = 0;
  logic [16:0] cur_txn;
  logic [16:0] tx_now;
  int          stall_left = 0;
  int          last_ack_cyc = 0;
  bit          last_ack_we = 0;
  bit          first_stb = 0;
  int          acc_cyc = 0;
  bit          in_seq = 0;
  bit          seq_done = 0;
  int          rd_accepts = 0;
  int          rx_count = 0;
  int          cur_len = 0;
  bit          rand_stall = 0;
  bit          rand_ack = 0;
  bit          rand_tready = 0;
  int          rx_stall = 0;
  bit          arm_tr_low = 0;
  int          tr_low_left = 0;
  bit          ax_prev_v = 0;
  bit          ax_prev_r = 0;
  logic [9:0]  ax_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input logic [23:0] a, input logic [7:0] len);
    exp_txn.delete();
    exp_bytes.delete();
    exp_txn.push_back({1'b1, 8'h01, 8'h02});
    exp_txn.push_back({1'b1, 8'h02, 8'h03});
    for (int i = 2; i >= 0; i--) exp_txn.push_back({1'b1, 8'h02, a[8*i +: 8]});
    exp_txn.push_back(TX_RX_ON);
    exp_txn.push_back({1'b1, 8'h03, len});
    for (int i = 0; i < int'(len); i++) exp_txn.push_back({1'b0, 8'h02, 8'h00});
    exp_txn.push_back(TX_CS_OFF);
  endtask

  task automatic clear_model();
    pend = 0; holding = 0; stall_left = 0; in_seq = 0; seq_done = 0;
    ax_prev_v = 0; tr_low_left = 0; arm_tr_low = 0;
    exp_txn.delete();
    exp_bytes.delete();
  endtask

  // One clock: observe outputs #1 after the edge and drive this cycle's inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    m_wb_ack   = 1'b0;
    m_wb_stall = 1'b0;
    if (!model_en) begin
      m_axis_tready = 1'b1;
    end else begin
      // stream side
      if (ax_prev_v && !ax_prev_r) chk("axis_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, ax_prev);
      if (arm_tr_low && m_axis_tvalid) begin
        tr_low_left = 10;
        arm_tr_low  = 0;
      end
      if (tr_low_left > 0) begin
        m_axis_tready = 1'b0;
        tr_low_left--;
      end else begin
        m_axis_tready = rand_tready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_bytes.size() == 0) chk("axis_extra", 1, 0);
        else begin
          chk("axis_data", m_axis_tdata, exp_bytes.pop_front());
          chk("axis_tlast", m_axis_tlast, (rx_count + 1 == cur_len));
        end
        rx_count++;
      end
      ax_prev_v = m_axis_tvalid;
      ax_prev_r = m_axis_tready;
      ax_prev   = {1'b1, m_axis_tlast, m_axis_tdata};

      // Wishbone slave side
      if (in_seq) chk("cyc_cont", m_wb_cyc, 1);
      tx_now = {m_wb_we, m_wb_addr, m_wb_we ? m_wb_dat_m2s : 8'h00};
      if (pend) begin
        chk("one_outstanding", m_wb_stb, 0);
        if (ack_wait == 0) begin
          m_wb_ack     = 1'b1;
          pend         = 0;
          last_ack_cyc = cyc_n;
          last_ack_we  = pend_txn[16];
          if (!pend_txn[16]) begin
            m_wb_dat_s2m = pend_rd;
            exp_bytes.push_back(pend_rd);
          end else begin
            m_wb_dat_s2m = 8'($urandom);
          end
          if (pend_txn == TX_CS_OFF) begin
            seq_done = 1;
            in_seq   = 0;
          end
        end else begin
          ack_wait--;
        end
      end else if (m_wb_stb) begin
        if (holding) chk("stb_hold", tx_now, cur_txn);
        else begin
          if (!m_wb_we) chk("rd_when_full", m_axis_tvalid, 0);
          if (first_stb) begin
            chk("first_stb_lat", cyc_n, acc_cyc + 1);
            first_stb = 0;
            in_seq    = 1;
          end else if (last_ack_we || m_wb_we) begin
            chk("op_gap", cyc_n, last_ack_cyc + 1);
          end
          cur_txn    = tx_now;
          holding    = 1;
          stall_left = (tx_now == TX_RX_ON) ? rx_stall : (rand_stall ? int'($urandom_range(0, 3)) : 0);
        end
        if (stall_left > 0) begin
          m_wb_stall = 1'b1;
          stall_left--;
        end else begin
          holding = 0;
          if (exp_txn.size() == 0) chk("txn_extra", 1, 0);
          else chk("txn", tx_now, exp_txn.pop_front());
          if (!m_wb_we) rd_accepts++;
          pend     = 1;
          pend_txn = tx_now;
          pend_rd  = 8'($urandom);
          ack_wait = rand_ack ? int'($urandom_range(0, 2)) : 0;
        end
      end else if (holding) begin
        chk("stb_drop", 0, 1);
        holding = 0;
      end
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [7:0] len);
    build_exp(a, len);
    cur_len    = int'(len);
    rx_count   = 0;
    seq_done   = 0;
    first_stb  = 1;
    rd_accepts = 0;
    req_addr   = a;
    req_len    = len;
    req_valid  = 1'b1;
    chk("req_ready_at_req", req_ready, 1);
    acc_cyc = cyc_n;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_req();
    for (int i = 0; i < 3000 && !(seq_done && rx_count == cur_len); i++) tick();
    chk("req_done", (seq_done && rx_count == cur_len), 1);
    tick();
    chk("end_cyc", m_wb_cyc, 0);
    chk("end_busy", busy, 0);
    chk("end_req_ready", req_ready, 1);
    chk("end_txn_left", exp_txn.size(), 0);
    chk("end_bytes_left", exp_bytes.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cyc"}, m_wb_cyc, 0);
    chk({tag, "_stb"}, m_wb_stb, 0);
    chk({tag, "_we"}, m_wb_we, 0);
    chk({tag, "_addr"}, m_wb_addr, 0);
    chk({tag, "_dat"}, m_wb_dat_m2s, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 3 cycles
    sresetn  = 1'b0;
    model_en = 0;
    repeat (3) tick();
    check_reset_values("rst");
    chk("rst_sel", m_wb_sel, 1);
    sresetn = 1'b1;
    tick();
    model_en = 1;

    // fixed request, ideal slave
    rand_stall = 0; rand_ack = 0; rand_tready = 0; rx_stall = 0;
    start_req(24'h123456, 8'd4);
    finish_req();

    // long RX_ON stall plus random stalls/latency on everything else
    rand_stall = 1; rand_ack = 1; rx_stall = 20;
    start_req(24'($urandom), 8'($urandom_range(1, 12)));
    finish_req();

    // consumer stalls 10 cycles once data starts flowing
    rand_stall = 0; rand_ack = 0; rx_stall = 0;
    arm_tr_low = 1;
    start_req(24'($urandom), 8'd8);
    finish_req();

    // zero-length request is dropped
    exp_txn.delete();
    req_addr  = 24'($urandom);
    req_len   = 8'd0;
    req_valid = 1'b1;
    chk("len0_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("len0_stb", m_wb_stb, 0);
      chk("len0_cyc", m_wb_cyc, 0);
      chk("len0_ready_hold", req_ready, 1);
      chk("len0_tvalid", m_axis_tvalid, 0);
      tick();
    end

    // reset while the second of five reads is outstanding
    start_req(24'($urandom), 8'd5);
    for (int i = 0; i < 200 && rd_accepts < 2; i++) tick();
    chk("reach_read2", rd_accepts, 2);
    sresetn  = 1'b0;
    model_en = 0;
    tick();
    check_reset_values("midrst");
    sresetn = 1'b1;
    clear_model();
    model_en = 1;
    tick();
    start_req(24'($urandom), 8'($urandom_range(1, 9)));
    finish_req();

    // random mix
    for (int r = 0; r < 6; r++) begin
      rand_stall  = 1'($urandom_range(0, 1));
      rand_ack    = 1'($urandom_range(0, 1));
      rand_tready = 1'($urandom_range(0, 1));
      rx_stall    = int'($urandom_range(0, 5));
      start_req(24'($urandom), 8'($urandom_range(1, 20)));
      finish_req();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_sequencer.md
# spi_flash_read_sequencer

Wishbone master that sequences the byte-wide SPI master register block to perform complete SPI-flash READ transactions. It accepts a request of {flash address, length}, drives chip select, command, address, dummy-byte injection and read-back through the SPI master's config (0x01), data (0x02) and inject (0x03) registers, then releases chip select. Read data is returned on an AXI-Stream output with tlast on the final byte. It sits between a client (boot loader, DMA) and the SPI master's Wishbone slave port.

## Interface
- CMD_READ, 8'h03, flash read opcode sent first.
- ADDR_BYTES, 3, flash address bytes sent MSB first; legal 1..4.
- clk  in  1  clock.
- sresetn  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  8*ADDR_BYTES  flash byte address.
- req_len  in  8  bytes to read, 1..255; 0 is a no-op.
- busy  out  1  high in any state except IDLE.
- m_axis_tvalid / m_axis_tready  out / in  1  read-data handshake.
- m_axis_tdata  out  8  read byte.
- m_axis_tlast  out  1  high on the req_len-th byte.
- m_wb_addr  out  8  register address.
- m_wb_dat_m2s / m_wb_dat_s2m  out / in  8  write / read data.
- m_wb_we, m_wb_sel(1), m_wb_stb, m_wb_cyc  out  1  pipelined Wishbone master controls; sel constant 1.
- m_wb_ack, m_wb_stall  in  1  slave responses.

## Operation
- States: IDLE, CS_ON, CMD, ADDR, RX_ON, INJECT, READ, CS_OFF.
- IDLE: req_ready=1; on req_valid, latch req_addr/req_len. req_len=0 → stay IDLE, no WB activity, no output. Otherwise → CS_ON.
- CS_ON: write 0x01 ← 0x02 (ss=0, discard=1).
- CMD: write 0x02 ← CMD_READ.
- ADDR: ADDR_BYTES writes to 0x02, MSB first; byte counter.
- RX_ON: write 0x01 ← 0x00 (ss=0, discard=0). Slave stalls until command/address bytes have shifted out; held until stall drops.
- INJECT: write 0x03 ← req_len.
- READ: req_len reads of 0x02; a read issues only when the output register is empty, or emptying in the same cycle.
- CS_OFF: write 0x01 ← 0x01 (ss=1); on ack → IDLE.
- Each WB op is one transaction: ISSUE (stb=1, addr/data/we valid, held until stall=0), then WAIT_ACK (stb=0 until ack). Exactly one outstanding transaction.
- m_wb_cyc=1 from the CS_ON issue through the CS_OFF ack, continuous; 0 in IDLE.
- Output register: on read ack, tdata←dat_s2m, tvalid←1, tlast←(last byte). Cleared on tvalid&&tready. Data is held stable while tvalid=1 and tready=0.

## Timing
- Reset values: req_ready=1, busy=0, m_wb_cyc=0, m_wb_stb=0, m_wb_we=0, m_wb_addr=0, m_wb_dat_m2s=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- req accepted in cycle T → first stb at T+1.
- Next op's stb is asserted at the earliest the cycle after the previous ack. No stall: 2 cycles per op.
- Read ack at cycle T → m_axis_tvalid=1 at T+1.
- Stall handling: stb stays asserted with unchanged addr/data for any number of stall cycles.
- Ack is ignored in ISSUE. Ack is only expected after an accepted stb.
- Reset mid-sequence returns to IDLE with reset values next cycle. The SPI master shares sresetn, so its ss also returns high. No partial-output recovery.
- No timeout: a slave that never acks hangs the block (busy=1).

## Structure
- Shared package spi_seq_pkg: register addresses (REG_CONFIG=8'h01, REG_DATA=8'h02, REG_INJECT=8'h03), config bit positions (SS=0, DISCARD=1), state enum.
- Sub-module wb_single_op_master: takes start/we/addr/wdata, drives the ISSUE/WAIT_ACK handshake, returns done plus rdata. The sequencer FSM drives one op at a time through it.

## Test plan
- Reset: hold sresetn=0 for 3 cycles → all outputs at reset values, cyc=0.
- Request addr 0x123456, len 4, model with no stall → WB sequence in this order:
  - 01←02, 02←03, 02←12, 02←34, 02←56
  - 01←00, 03←04
  - 4× read 02
  - 01←01
  
  Then the 4 model bytes appear on m_axis, tlast only on byte 4, and cyc drops after the final ack.
- Model stalls RX_ON write for 20 cycles and random-stalls reads → stb/addr/data held stable, no duplicated or lost transactions, output bytes identical.
- m_axis_tready low for 10 cycles during len 8 → no WB read issued while output full, no byte lost, order preserved.
- req_len=0 → req_ready stays 1, no stb/cyc ever, no output.
- sresetn pulsed during READ of byte 2 of 5 → IDLE next cycle, tvalid=0, cyc=0. A new request then completes correctly.
